// File: rtl/clock_pkg.sv
// clock_pkg: shared mode, field-select and countdown-state encodings for the clock system
package clock_pkg;
  localparam logic [1:0] MODE_CLOCK = 2'b00;
  localparam logic [1:0] MODE_ALARM = 2'b01;
  localparam logic [1:0] MODE_STOPWATCH = 2'b10;
  localparam logic [1:0] MODE_COUNTDOWN = 2'b11;
  localparam logic [1:0] SEL_SEC = 2'b00;
  localparam logic [1:0] SEL_MIN = 2'b01;
  localparam logic [1:0] SEL_HOUR = 2'b10;
  localparam logic [5:0] SEC_MAX = 6'd59;
  typedef enum logic [1:0] {CD_IDLE = 2'b00, CD_RUN = 2'b01, CD_PAUSE = 2'b10, CD_DONE = 2'b11} cd_state_t;
  function automatic logic [5:0] step_wrap(input logic [5:0] v, input logic [5:0] max, input logic up);
    return up ? (v >= max ? 6'd0 : v + 6'd1) : (v == 6'd0 ? max : v - 6'd1);
  endfunction
endpackage

// File: rtl/hms_counter.sv
// hms_counter: hh:mm:ss registers with load, clear, wrapping field edit and borrow decrement
module hms_counter
  import clock_pkg::*;
#(
  parameter int MAX_HOUR = 23
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       load,
  input  logic [4:0] load_hour,
  input  logic [5:0] load_min,
  input  logic [5:0] load_sec,
  input  logic       inc,
  input  logic       dec,
  input  logic [1:0] sel,
  input  logic       tick_dec,
  output logic [4:0] hour,
  output logic [5:0] min,
  output logic [5:0] sec,
  output logic       is_zero,
  output logic       is_one
);
  logic [5:0] h_step;
  assign h_step = step_wrap({1'b0, hour}, 6'(MAX_HOUR), inc);
  assign is_zero = hour == 5'd0 && min == 6'd0 && sec == 6'd0;
  assign is_one = hour == 5'd0 && min == 6'd0 && sec == 6'd1;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hour <= '0;
      min <= '0;
      sec <= '0;
    end else if (clr) begin
      hour <= '0;
      min <= '0;
      sec <= '0;
    end else if (load) begin
      hour <= load_hour;
      min <= load_min;
      sec <= load_sec;
    end else if (inc ^ dec) begin
      if (sel == SEL_HOUR) hour <= h_step[4:0];
      else if (sel == SEL_MIN) min <= step_wrap(min, SEC_MAX, inc);
      else sec <= step_wrap(sec, SEC_MAX, inc);
    end else if (tick_dec && !is_zero) begin
      if (sec != 6'd0) sec <= sec - 6'd1;
      else if (min != 6'd0) begin
        min <= min - 6'd1;
        sec <= SEC_MAX;
      end else begin
        hour <= hour - 5'd1;
        min <= SEC_MAX;
        sec <= SEC_MAX;
      end
    end
  end
endmodule

// File: rtl/countdown_ctrl.sv
// countdown_ctrl: countdown FSM, preset and expiry beep around an hms_counter
module countdown_ctrl
  import clock_pkg::*;
#(
  parameter int BEEP_SEC = 10,
  parameter int MAX_HOUR = 23
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] model,
  input  logic [1:0] adjust_shif,
  input  logic       key_up,
  input  logic       key_down,
  input  logic       start_key,
  input  logic       clear,
  input  logic       sec_tick,
  output logic [4:0] cd_hour,
  output logic [5:0] cd_min,
  output logic [5:0] cd_sec,
  output logic [1:0] cd_state,
  output logic       beep
);
  cd_state_t state, nxt;
  logic [4:0] pre_hour;
  logic [5:0] pre_min, pre_sec, bcnt, bcnt_nxt;
  logic beep_nxt, h_clr, h_load, h_inc, h_dec, h_tick, pre_ld, is_zero, is_one;
  logic en, c, s, u, d;
  assign en = model == MODE_COUNTDOWN;
  assign c = clear & en;
  assign s = start_key & en;
  assign u = key_up & en;
  assign d = key_down & en;
  assign cd_state = state;
  always_comb begin
    nxt = state;
    bcnt_nxt = bcnt;
    beep_nxt = beep;
    h_clr = 1'b0;
    h_load = 1'b0;
    h_inc = 1'b0;
    h_dec = 1'b0;
    h_tick = 1'b0;
    pre_ld = 1'b0;
    if (c) begin
      nxt = CD_IDLE;
      h_clr = 1'b1;
      beep_nxt = 1'b0;
      bcnt_nxt = '0;
    end else begin
      case (state)
        CD_IDLE: begin
          pre_ld = s && !is_zero;
          nxt = pre_ld ? CD_RUN : CD_IDLE;
          h_inc = !s && u;
          h_dec = !s && d;
        end
        CD_RUN: begin
          nxt = s ? CD_PAUSE : (sec_tick && is_one) ? CD_DONE : CD_RUN;
          h_tick = !s && sec_tick;
          beep_nxt = !s && sec_tick && is_one;
          bcnt_nxt = beep_nxt ? 6'(BEEP_SEC) : bcnt;
        end
        CD_PAUSE: begin
          nxt = s ? (is_zero ? CD_IDLE : CD_RUN) : CD_PAUSE;
          h_inc = !s && u;
          h_dec = !s && d;
        end
        default: begin
          // keys silence at once; otherwise the beep runs out on ticks
          h_load = s || u || d || (sec_tick && bcnt <= 6'd1);
          bcnt_nxt = h_load ? 6'd0 : sec_tick ? bcnt - 6'd1 : bcnt;
          beep_nxt = !h_load;
          nxt = h_load ? CD_IDLE : CD_DONE;
        end
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= CD_IDLE;
      bcnt <= '0;
      beep <= 1'b0;
      pre_hour <= '0;
      pre_min <= '0;
      pre_sec <= '0;
    end else begin
      state <= nxt;
      bcnt <= bcnt_nxt;
      beep <= beep_nxt;
      if (c) begin
        pre_hour <= '0;
        pre_min <= '0;
        pre_sec <= '0;
      end else if (pre_ld) begin
        pre_hour <= cd_hour;
        pre_min <= cd_min;
        pre_sec <= cd_sec;
      end
    end
  end
  hms_counter #(.MAX_HOUR(MAX_HOUR)) u_hms (
    .clk(clk),
    .rst_n(rst_n),
    .clr(h_clr),
    .load(h_load),
    .load_hour(pre_hour),
    .load_min(pre_min),
    .load_sec(pre_sec),
    .inc(h_inc),
    .dec(h_dec),
    .sel(adjust_shif),
    .tick_dec(h_tick),
    .hour(cd_hour),
    .min(cd_min),
    .sec(cd_sec),
    .is_zero(is_zero),
    .is_one(is_one)
  );
endmodule

// File: tb/tb_countdown_ctrl.sv
// tb_countdown_ctrl: directed checks of the countdown controller with hand-computed expectations
module tb_countdown_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] model = 2'b11;
  logic [1:0] adjust_shif = 2'b00;
  logic key_up = 1'b0, key_down = 1'b0, start_key = 1'b0, clear = 1'b0, sec_tick = 1'b0;
  logic [4:0] cd_hour;
  logic [5:0] cd_min, cd_sec;
  logic [1:0] cd_state;
  logic beep;
  int errors = 0;
  int checks = 0;
  always #5 clk = ~clk;
  countdown_ctrl dut (
    .clk(clk),
    .rst_n(rst_n),
    .model(model),
    .adjust_shif(adjust_shif),
    .key_up(key_up),
    .key_down(key_down),
    .start_key(start_key),
    .clear(clear),
    .sec_tick(sec_tick),
    .cd_hour(cd_hour),
    .cd_min(cd_min),
    .cd_sec(cd_sec),
    .cd_state(cd_state),
    .beep(beep)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic chk_all(input string tag, input int h, input int m, input int s, input int st, input int b);
    chk({tag, ".hour"}, 32'(cd_hour), 32'(h));
    chk({tag, ".min"}, 32'(cd_min), 32'(m));
    chk({tag, ".sec"}, 32'(cd_sec), 32'(s));
    chk({tag, ".state"}, 32'(cd_state), 32'(st));
    chk({tag, ".beep"}, 32'(beep), 32'(b));
  endtask
  task automatic step(input logic u, input logic d, input logic s, input logic c, input logic t);
    @(negedge clk);
    key_up = u;
    key_down = d;
    start_key = s;
    clear = c;
    sec_tick = t;
    @(negedge clk);
    key_up = 1'b0;
    key_down = 1'b0;
    start_key = 1'b0;
    clear = 1'b0;
    sec_tick = 1'b0;
  endtask
  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 1);
  endtask
  initial begin
    #12;
    chk_all("reset", 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    adjust_shif = 2'b00;
    step(0, 1, 0, 0, 0);
    chk("sec_down_wrap", 32'(cd_sec), 32'd59);
    adjust_shif = 2'b10;
    step(0, 1, 0, 0, 0);
    chk("hour_down_wrap", 32'(cd_hour), 32'd23);
    step(1, 0, 0, 0, 0);
    chk("hour_up_wrap", 32'(cd_hour), 32'd0);
    adjust_shif = 2'b11;
    step(1, 0, 0, 0, 0);
    chk("sel11_sec_up_wrap", 32'(cd_sec), 32'd0);
    adjust_shif = 2'b01;
    step(1, 0, 0, 0, 0);
    adjust_shif = 2'b00;
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    chk_all("set_0102", 0, 1, 2, 0, 0);
    step(0, 0, 1, 0, 0);
    chk("start_run", 32'(cd_state), 32'd1);
    ticks(3);
    chk_all("run_3ticks", 0, 0, 59, 1, 0);
    step(0, 0, 1, 0, 0);
    ticks(5);
    chk_all("pause_hold", 0, 0, 59, 2, 0);
    step(0, 0, 1, 0, 0);
    chk("resume", 32'(cd_state), 32'd1);
    step(0, 0, 0, 1, 0);
    chk_all("clear_run", 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    ticks(2);
    chk_all("expire", 0, 0, 0, 3, 1);
    ticks(9);
    chk_all("beep_9ticks", 0, 0, 0, 3, 1);
    ticks(1);
    chk_all("beep_end_restore", 0, 0, 2, 0, 0);
    step(0, 0, 1, 0, 0);
    ticks(2);
    chk("expire2", 32'(cd_state), 32'd3);
    step(0, 0, 1, 0, 0);
    chk_all("done_start_silence", 0, 0, 2, 0, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 1, 0, 0);
    chk_all("start_at_zero", 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    model = 2'b00;
    ticks(1);
    chk("bg_tick", 32'(cd_sec), 32'd2);
    step(1, 0, 0, 0, 0);
    chk("bg_up_ignored", 32'(cd_sec), 32'd2);
    step(0, 0, 1, 0, 0);
    chk("bg_start_ignored", 32'(cd_state), 32'd1);
    step(0, 0, 0, 1, 0);
    chk("bg_clear_ignored", 32'(cd_state), 32'd1);
    model = 2'b11;
    step(0, 0, 0, 1, 1);
    chk_all("clear_with_tick", 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 1);
    chk_all("start_tick_pause", 0, 0, 5, 2, 0);
    step(1, 1, 0, 0, 0);
    chk("pause_updn", 32'(cd_sec), 32'd5);
    step(0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    chk("idle_updn", 32'(cd_sec), 32'd1);
    adjust_shif = 2'b01;
    step(0, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    ticks(2);
    chk_all("borrow", 0, 58, 59, 1, 0);
    rst_n = 1'b0;
    #2;
    chk_all("async_reset", 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/countdown_ctrl.md
Name: countdown_ctrl

Overview:
- Sequences the countdown-timer datapath for mode 2'b11 of the clock system.
- Consumes one-cycle key flags (up, down, start/stop, clear) and field-select/mode levels from the key front end, plus the 1 Hz tick.
- Owns the hh:mm:ss countdown registers and the preset, and drives the display value and the expiry beep request.

Parameters:
- BEEP_SEC, 10, beep duration in seconds after expiry (1..63).
- MAX_HOUR, 23, highest settable hour value.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- model  in  2  current mode; 2'b11 = countdown, block accepts keys only in this mode
- adjust_shif  in  2  field select: 00 = sec, 01 = min, 10 = hour, 11 = treated as 00
- key_up  in  1  one-cycle flag, +1 on selected field
- key_down  in  1  one-cycle flag, -1 on selected field
- start_key  in  1  one-cycle flag, start/pause/resume
- clear  in  1  one-cycle flag, abort and zero
- sec_tick  in  1  one-cycle 1 Hz strobe
- cd_hour  out  5  current hours, 0..MAX_HOUR
- cd_min  out  6  current minutes, 0..59
- cd_sec  out  6  current seconds, 0..59
- cd_state  out  2  00 = IDLE, 01 = RUN, 10 = PAUSE, 11 = DONE
- beep  out  1  high while in DONE

Behaviour:
- Reset: state IDLE; cd_hour, cd_min, cd_sec = 0; preset = 0; beep = 0; beep counter = 0.
- Key enable: key flags are acted on only when model == 2'b11. sec_tick is always acted on, so the countdown runs in the background when another mode is displayed.
- Per-cycle priority: clear > start_key > key_up/key_down > sec_tick.
  - clear: any state -> IDLE; value = 0; preset = 0; beep = 0.
- IDLE:
  - key_up/key_down edit the selected field with wrap: sec/min 59 <-> 0, hour MAX_HOUR <-> 0.
  - key_up and key_down in the same cycle: no change.
  - start_key with value != 0: preset <= value; -> RUN.
  - start_key with value == 0: ignored.
- RUN:
  - sec_tick decrements with borrow:
    - sec > 0: sec - 1.
    - else min > 0: min - 1, sec = 59.
    - else hour - 1, min = 59, sec = 59.
  - Tick when value == 00:00:01: value becomes 0, -> DONE, beep = 1, beep counter = BEEP_SEC. Next-cycle latency from the tick.
  - start_key -> PAUSE; a tick in the same cycle is discarded.
  - Up/down ignored.
- PAUSE:
  - Ticks ignored.
  - Up/down edit as in IDLE; preset is not updated.
  - start_key: value != 0 -> RUN; value == 0 -> IDLE.
- DONE:
  - Each sec_tick decrements the beep counter; on reaching 0: beep = 0, value = preset, -> IDLE.
  - start_key or up/down (mode 11 only): immediate silence, value = preset, -> IDLE.
- Outputs are registered; no combinational path from inputs to outputs.
- Field values never leave their legal range, whatever the key sequence.
- Reset asserted mid-run returns everything to reset values immediately.

Decomposition:
- Shared package (clock_pkg):
  - MODE_CLOCK / ALARM / STOPWATCH / COUNTDOWN = 00 / 01 / 10 / 11.
  - Field-select codes SEL_SEC / SEL_MIN / SEL_HOUR.
  - cd_state encodings.
  - Constant SEC_MAX = 59.
- Sub-module hms_counter:
  - Holds hour/min/sec registers.
  - Supports load, clear, field inc/dec with wrap, and borrow-decrement.
  - Reports is_zero and is_one.
  - Reusable by the stopwatch and alarm blocks.
- countdown_ctrl holds the FSM, preset and beep counter.

Test Plan:
- Reset, model = 11, adjust_shif = 00, key_down x1 -> cd_sec = 59; adjust_shif = 10, key_down -> cd_hour = 23; key_up -> cd_hour = 0.
- Set 00:01:02, start_key, 3 ticks -> 00:00:59 with cd_state = 01; start_key -> PAUSE; 5 ticks -> still 00:00:59; start_key -> RUN.
- Set 00:00:02, start, 2 ticks -> value 0, cd_state = 11, beep = 1; 10 more ticks -> beep = 0, IDLE, value restored to 00:00:02.
- In DONE, start_key -> beep = 0 next cycle, IDLE, value = preset; start_key at 00:00:00 in IDLE -> stays IDLE.
- RUN with model switched to 00: ticks still decrement; key_up/start_key ignored. clear and sec_tick in the same cycle -> IDLE, all zero.
- start_key coincident with sec_tick in RUN -> PAUSE, value unchanged; key_up + key_down together in IDLE -> no change; rst_n low mid-RUN -> all outputs 0 asynchronously.
